bit_serializer: RTL and testbench

- Upstream stage of the 5-bit pattern detector.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on `dout`, which drives the detector's 1-bit `din`.
- A one-deep holding register gives back-to-back words with no idle bit between them.
- When no word is in flight, `dout` drives a constant idle level so the detector always sees defined data.

---
 rtl/serdes_pkg.sv | 19 +
 rtl/bit_serializer_if.sv | 23 ++
 rtl/bit_serializer.sv | 123 ++++++++++++
 tb/tb_bit_serializer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// Shared definitions for the serializer and the downstream pattern detector.
package serdes_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  localparam int   DEF_WIDTH    = 8;
  localparam logic IDLE_BIT_DEF = 1'b0;

  // Bit-counter width for a given word width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/bit_serializer_if.sv
// Word-in / bit-out bus between a word source, the serializer and the detector.
interface bit_serializer_if #(
  parameter int WIDTH = serdes_pkg::DEF_WIDTH
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             dout;
  logic             dout_valid;
  logic             busy;

  // Word source / observer side.
  modport master (
    output data_in, data_valid,
    input  data_ready, dout, dout_valid, busy
  );

  // Serializer side.
  modport slave (
    input  data_in, data_valid,
    output data_ready, dout, dout_valid, busy
  );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-deep holding register so
// back-to-back words leave with no idle bit between them.
module bit_serializer
  import serdes_pkg::*;
#(
  parameter int   WIDTH     = DEF_WIDTH,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = IDLE_BIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  bit_serializer_if.slave   bus
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;

  logic             accept;
  logic             last_bit;

  // First bit to emit from a word that is aligned for shifting.
  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Drop the bit just emitted so the next one sits at the head.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // Ready depends only on the hold flop, never on data_valid.
  assign accept   = bus.data_valid && !hold_full_q;
  assign last_bit = (cnt_q == LAST_CNT);

  // Next-state: load, shift, hold-buffer and return-to-idle decisions.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = SHIFT;
          cnt_d        = '0;
          dout_d       = head(bus.data_in);
          shreg_d      = advance(bus.data_in);
          dout_valid_d = 1'b1;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          // accept implies the hold register is empty, so a held word and a
          // fresh word never compete for the shift register here.
          if (hold_full_q) begin
            cnt_d       = '0;
            dout_d      = head(hold_q);
            shreg_d     = advance(hold_q);
            hold_full_d = 1'b0;
          end else if (accept) begin
            cnt_d   = '0;
            dout_d  = head(bus.data_in);
            shreg_d = advance(bus.data_in);
          end else begin
            state_d      = IDLE;
            cnt_d        = '0;
            dout_d       = IDLE_BIT;
            dout_valid_d = 1'b0;
          end
        end else begin
          dout_d  = head(shreg_q);
          shreg_d = advance(shreg_q);
          cnt_d   = cnt_q + CNT_W'(1);
          if (accept) begin
            hold_d      = bus.data_in;
            hold_full_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any partial or held word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      dout_q       <= IDLE_BIT;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign bus.data_ready = !hold_full_q;
  assign bus.busy       = (state_q == SHIFT) || hold_full_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench: expected bits are queued when a word is accepted and
// popped whenever dout_valid is seen.
module tb_bit_serializer;
  import serdes_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  bit   exp_q[$];

  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(8)) if8 ();
  bit_serializer_if #(.WIDTH(5)) if5 ();
  bit_serializer_if #(.WIDTH(8)) ifl ();
  bit_serializer_if #(.WIDTH(4)) if4 ();

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_w8 (.clk(clk), .reset(reset), .bus(if8));
  bit_serializer #(.WIDTH(5), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_w5 (.clk(clk), .reset(reset), .bus(if5));
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_l8 (.clk(clk), .reset(reset), .bus(ifl));
  bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_w4 (.clk(clk), .reset(reset), .bus(if4));

  task automatic push_word(input logic [31:0] w, input int width, input bit msb);
    for (int i = 0; i < width; i++) exp_q.push_back(msb ? w[width-1-i] : w[i]);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (if8.dout !== 1'b0) begin errors++; $display("FAIL rst_dout: got %b want 0", if8.dout); end
    checks++; if (if8.dout_valid !== 1'b0) begin errors++; $display("FAIL rst_dout_valid: got %b want 0", if8.dout_valid); end
    checks++; if (if8.data_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", if8.data_ready); end
    checks++; if (if8.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", if8.busy); end
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (if8.dout !== 1'b0) begin errors++; $display("FAIL idle_dout c=%0d: got %b want 0", c, if8.dout); end
      checks++; if (if8.dout_valid !== 1'b0) begin errors++; $display("FAIL idle_valid c=%0d: got %b want 0", c, if8.dout_valid); end
      checks++; if (if8.data_ready !== 1'b1) begin errors++; $display("FAIL idle_ready c=%0d: got %b want 1", c, if8.data_ready); end
      checks++; if (if8.busy !== 1'b0) begin errors++; $display("FAIL idle_busy c=%0d: got %b want 0", c, if8.busy); end
    end
  endtask

  task automatic test_w5_single();
    logic e;
    logic exp_v;
    exp_q.delete();
    @(negedge clk);
    if5.data_in = 5'b01101; if5.data_valid = 1'b1;
    checks++; if (if5.data_ready !== 1'b1) begin errors++; $display("FAIL w5_ready: got %b want 1", if5.data_ready); end
    push_word(32'b01101, 5, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      exp_v = (c <= 5);
      checks++; if (if5.dout_valid !== exp_v) begin errors++; $display("FAIL w5_valid c=%0d: got %b want %b", c, if5.dout_valid, exp_v); end
      if (if5.dout_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL w5_extra c=%0d: got bit %b want none", c, if5.dout); end
        else begin
          e = exp_q.pop_front();
          if (if5.dout !== e) begin errors++; $display("FAIL w5_bit c=%0d: got %b want %b", c, if5.dout, e); end
        end
      end else begin
        checks++; if (if5.dout !== 1'b0) begin errors++; $display("FAIL w5_idle c=%0d: got %b want 0", c, if5.dout); end
      end
      if (c == 1) if5.data_valid = 1'b0;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL w5_left: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w [3];
    logic e;
    logic exp_v;
    int idx = 0;
    int low_cnt = 0;
    w[0] = 8'hA5; w[1] = 8'h3C; w[2] = 8'hFF;
    exp_q.delete();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c > 0) begin
        exp_v = (c <= 24);
        checks++; if (if8.dout_valid !== exp_v) begin errors++; $display("FAIL b2b_valid c=%0d: got %b want %b", c, if8.dout_valid, exp_v); end
        if (if8.dout_valid === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_extra c=%0d: got bit %b want none", c, if8.dout); end
          else begin
            e = exp_q.pop_front();
            if (if8.dout !== e) begin errors++; $display("FAIL b2b_bit c=%0d: got %b want %b", c, if8.dout, e); end
          end
        end
        if (if8.data_ready === 1'b0) low_cnt++;
        if (c == 2) begin
          checks++; if (if8.data_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_2nd: got %b want 0", if8.data_ready); end
        end
      end
      if (idx < 3) begin
        if8.data_valid = 1'b1; if8.data_in = w[idx];
        if (if8.data_ready === 1'b1) begin push_word(32'(w[idx]), 8, 1'b1); idx++; end
      end else begin
        if8.data_valid = 1'b0;
      end
    end
    checks++; if (idx != 3) begin errors++; $display("FAIL b2b_accepts: got %0d want 3", idx); end
    checks++; if (low_cnt != 14) begin errors++; $display("FAIL b2b_ready_low: got %0d want 14", low_cnt); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_left: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_lsb_first();
    logic e;
    logic exp_v;
    exp_q.delete();
    @(negedge clk);
    ifl.data_in = 8'h01; ifl.data_valid = 1'b1;
    push_word(32'h01, 8, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      exp_v = (c <= 8);
      checks++; if (ifl.dout_valid !== exp_v) begin errors++; $display("FAIL lsb_valid c=%0d: got %b want %b", c, ifl.dout_valid, exp_v); end
      if (ifl.dout_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL lsb_extra c=%0d: got bit %b want none", c, ifl.dout); end
        else begin
          e = exp_q.pop_front();
          if (ifl.dout !== e) begin errors++; $display("FAIL lsb_bit c=%0d: got %b want %b", c, ifl.dout, e); end
        end
      end
      if (c == 1) ifl.data_valid = 1'b0;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL lsb_left: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_last_edge_accept();
    logic e;
    logic exp_v;
    exp_q.delete();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c > 0) begin
        exp_v = (c <= 8);
        checks++; if (if4.dout_valid !== exp_v) begin errors++; $display("FAIL last_valid c=%0d: got %b want %b", c, if4.dout_valid, exp_v); end
        if (if4.dout_valid === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin errors++; $display("FAIL last_extra c=%0d: got bit %b want none", c, if4.dout); end
          else begin
            e = exp_q.pop_front();
            if (if4.dout !== e) begin errors++; $display("FAIL last_bit c=%0d: got %b want %b", c, if4.dout, e); end
          end
        end
        checks++; if (if4.data_ready !== 1'b1) begin errors++; $display("FAIL last_hold c=%0d: ready got %b want 1", c, if4.data_ready); end
      end
      if (c == 0) begin if4.data_in = 4'hF; if4.data_valid = 1'b1; push_word(32'hF, 4, 1'b1); end
      else if (c == 4) begin if4.data_in = 4'h0; if4.data_valid = 1'b1; push_word(32'h0, 4, 1'b1); end
      else if4.data_valid = 1'b0;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL last_left: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic e;
    exp_q.delete();
    @(negedge clk);
    if8.data_in = 8'hA5; if8.data_valid = 1'b1;
    push_word(32'hA5, 8, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) if8.data_in = 8'h3C;
      else if8.data_valid = 1'b0;
      checks++;
      if (exp_q.size() == 0 || if8.dout_valid !== 1'b1) begin errors++; $display("FAIL rmid_valid c=%0d: got %b want 1", c, if8.dout_valid); end
      else begin
        e = exp_q.pop_front();
        if (if8.dout !== e) begin errors++; $display("FAIL rmid_bit c=%0d: got %b want %b", c, if8.dout, e); end
      end
      if (c == 2) begin
        checks++; if (if8.data_ready !== 1'b0) begin errors++; $display("FAIL rmid_held: ready got %b want 0", if8.data_ready); end
      end
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (if8.dout !== 1'b0) begin errors++; $display("FAIL rmid_async_dout: got %b want 0", if8.dout); end
    checks++; if (if8.dout_valid !== 1'b0) begin errors++; $display("FAIL rmid_async_valid: got %b want 0", if8.dout_valid); end
    checks++; if (if8.data_ready !== 1'b1) begin errors++; $display("FAIL rmid_async_ready: got %b want 1", if8.data_ready); end
    checks++; if (if8.busy !== 1'b0) begin errors++; $display("FAIL rmid_async_busy: got %b want 0", if8.busy); end
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++; if (if8.dout_valid !== 1'b0 || if8.dout !== 1'b0) begin errors++; $display("FAIL rmid_residual c=%0d: got valid=%b dout=%b want 0/0", c, if8.dout_valid, if8.dout); end
      checks++; if (if8.data_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready c=%0d: got %b want 1", c, if8.data_ready); end
    end
  endtask

  initial begin
    if8.data_valid = 1'b0; if8.data_in = '0;
    if5.data_valid = 1'b0; if5.data_in = '0;
    ifl.data_valid = 1'b0; ifl.data_in = '0;
    if4.data_valid = 1'b0; if4.data_in = '0;
    test_reset();
    test_w5_single();
    test_back_to_back();
    test_lsb_first();
    test_last_edge_accept();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule
